// File: rtl/exc_commit_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Package  : cp0_pkg
// Purpose  : Shared CP0 definitions for the exception commit path:
//            ExcCode values, CP0 register numbers/selects, bit positions of
//            the per-slot exception cause vector and the commit FSM states.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
package cp0_pkg;

   // ExcCode values written into Cause.ExcCode
   localparam logic [4:0] EXC_INT  = 5'h00;
   localparam logic [4:0] EXC_ADEL = 5'h04;
   localparam logic [4:0] EXC_ADES = 5'h05;
   localparam logic [4:0] EXC_SYS  = 5'h08;
   localparam logic [4:0] EXC_BP   = 5'h09;
   localparam logic [4:0] EXC_RI   = 5'h0a;
   localparam logic [4:0] EXC_OV   = 5'h0c;
   localparam logic [4:0] EXC_TR   = 5'h0d;
   localparam logic [4:0] EXC_ERET = 5'h0e;

   // CP0 register numbers and select fields
   localparam logic [4:0] CP0_REG_STATUS = 5'd12;
   localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
   localparam logic [4:0] CP0_REG_EPC    = 5'd14;
   localparam logic [4:0] CP0_REG_EBASE  = 5'd15;
   localparam logic [2:0] CP0_SEL_STATUS = 3'd0;
   localparam logic [2:0] CP0_SEL_CAUSE  = 3'd0;
   localparam logic [2:0] CP0_SEL_EPC    = 3'd0;
   localparam logic [2:0] CP0_SEL_EBASE  = 3'd1;

   // Bit positions inside the 9-bit per-slot cause vector
   localparam int EXC_BIT_ADEL_IF  = 8;
   localparam int EXC_BIT_RI       = 7;
   localparam int EXC_BIT_OV       = 6;
   localparam int EXC_BIT_TR       = 5;
   localparam int EXC_BIT_SYS      = 4;
   localparam int EXC_BIT_BP       = 3;
   localparam int EXC_BIT_ERET     = 2;
   localparam int EXC_BIT_ADEL_MEM = 1;
   localparam int EXC_BIT_ADES     = 0;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } commit_state_t;

   // True when the WB-stage mtc0 targets the given CP0 register/select
   function automatic logic cp0_wr_hit(input logic       we,
                                       input logic [4:0] waddr,
                                       input logic [2:0] wsel,
                                       input logic [4:0] reg_num,
                                       input logic [2:0] reg_sel);
      return we && (waddr == reg_num) && (wsel == reg_sel);
   endfunction

endpackage
`default_nettype wire

// File: rtl/exc_commit_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Interface : exc_commit_ctrl_if
// Purpose   : Bundles the MEM-stage slot information, CP0 register values,
//             WB mtc0 bypass, and the CP0 exception-update / flush outputs.
// Modports  : master - pipeline/CP0 side (drives slot data, observes commit)
//             slave  - exc_commit_ctrl
// Revision  : 1.0  initial release
// ---------------------------------------------------------------------------
interface exc_commit_ctrl_if;

   logic        stall_i;
   logic        valid1_i;
   logic        valid2_i;
   logic [8:0]  exc1_i;
   logic [8:0]  exc2_i;
   logic [31:0] inst1_addr_i;
   logic [31:0] inst2_addr_i;
   logic        ds1_i;
   logic        ds2_i;
   logic [31:0] mem_addr_i;
   logic [31:0] status_i;
   logic [31:0] cause_i;
   logic [31:0] epc_i;
   logic [31:0] ebase_i;
   logic [5:0]  int_i;
   logic        cp0_we_i;
   logic [4:0]  cp0_waddr_i;
   logic [2:0]  cp0_wsel_i;
   logic [31:0] cp0_wdata_i;

   logic        exception_flag_o;
   logic [4:0]  exception_type_o;
   logic        exception_first_inst_o;
   logic [31:0] inst1_addr_o;
   logic [31:0] inst2_addr_o;
   logic [31:0] mem_addr_o;
   logic        ds1_o;
   logic        ds2_o;
   logic        flush_o;
   logic [31:0] new_pc_o;

   modport master (
      output stall_i, valid1_i, valid2_i, exc1_i, exc2_i,
             inst1_addr_i, inst2_addr_i, ds1_i, ds2_i, mem_addr_i,
             status_i, cause_i, epc_i, ebase_i, int_i,
             cp0_we_i, cp0_waddr_i, cp0_wsel_i, cp0_wdata_i,
      input  exception_flag_o, exception_type_o, exception_first_inst_o,
             inst1_addr_o, inst2_addr_o, mem_addr_o, ds1_o, ds2_o,
             flush_o, new_pc_o
   );

   modport slave (
      input  stall_i, valid1_i, valid2_i, exc1_i, exc2_i,
             inst1_addr_i, inst2_addr_i, ds1_i, ds2_i, mem_addr_i,
             status_i, cause_i, epc_i, ebase_i, int_i,
             cp0_we_i, cp0_waddr_i, cp0_wsel_i, cp0_wdata_i,
      output exception_flag_o, exception_type_o, exception_first_inst_o,
             inst1_addr_o, inst2_addr_o, mem_addr_o, ds1_o, ds2_o,
             flush_o, new_pc_o
   );

endinterface
`default_nettype wire

// File: rtl/exc_prio_enc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : exc_prio_enc
// Purpose  : Fixed-priority encoder for one issue slot. Reduces the slot's
//            cause vector plus an attached interrupt to {hit, ExcCode}.
// Ports    : exc      in  9  cause bits {adel_if,ri,ov,tr,sys,bp,eret,adel_mem,ades}
//            int_pend in  1  interrupt attached to this slot
//            hit      out 1  any cause present
//            code     out 5  ExcCode of the highest-priority cause
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module exc_prio_enc
   import cp0_pkg::*;
(
   input  logic [8:0] exc,
   input  logic       int_pend,
   output logic       hit,
   output logic [4:0] code
);

   // Interrupt outranks every synchronous cause; fetch faults outrank decode
   // and execute faults, memory-access faults come last.
   always_comb begin
      hit  = 1'b1;
      code = EXC_INT;
      if (int_pend)                     code = EXC_INT;
      else if (exc[EXC_BIT_ADEL_IF])    code = EXC_ADEL;
      else if (exc[EXC_BIT_RI])         code = EXC_RI;
      else if (exc[EXC_BIT_OV])         code = EXC_OV;
      else if (exc[EXC_BIT_TR])         code = EXC_TR;
      else if (exc[EXC_BIT_SYS])        code = EXC_SYS;
      else if (exc[EXC_BIT_BP])         code = EXC_BP;
      else if (exc[EXC_BIT_ERET])       code = EXC_ERET;
      else if (exc[EXC_BIT_ADEL_MEM])   code = EXC_ADEL;
      else if (exc[EXC_BIT_ADES])       code = EXC_ADES;
      else begin
         hit  = 1'b0;
         code = EXC_INT;
      end
   end

endmodule
`default_nettype wire

// File: rtl/exc_commit_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : exc_commit_ctrl
// Purpose  : Dual-issue MEM-stage exception commit. Picks the oldest
//            excepting slot, drives the CP0 exception update, and issues a
//            multi-cycle pipeline flush with the redirect PC.
// Ports    : clk  in  1  clock
//            rst  in  1  synchronous active-high reset
//            bus  exc_commit_ctrl_if.slave  slot data, CP0 values, mtc0
//                 bypass in; exception update, flush and new PC out
// Params   : FLUSH_CYCLES  cycles flush_o stays high per commit (>=1)
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module exc_commit_ctrl
   import cp0_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2
)(
   input  logic                     clk,
   input  logic                     rst,
   exc_commit_ctrl_if.slave         bus
);

   localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

   // ---------------------------------------------------------------------
   // CP0 bypass from the same-cycle WB mtc0
   // ---------------------------------------------------------------------
   logic        wr_status, wr_cause, wr_epc, wr_ebase;
   logic [7:0]  im;
   logic        exl, ie;
   logic [1:0]  ip_sw;
   logic [31:0] epc_byp, ebase_byp;

   assign wr_status = cp0_wr_hit(bus.cp0_we_i, bus.cp0_waddr_i, bus.cp0_wsel_i,
                                 CP0_REG_STATUS, CP0_SEL_STATUS);
   assign wr_cause  = cp0_wr_hit(bus.cp0_we_i, bus.cp0_waddr_i, bus.cp0_wsel_i,
                                 CP0_REG_CAUSE, CP0_SEL_CAUSE);
   assign wr_epc    = cp0_wr_hit(bus.cp0_we_i, bus.cp0_waddr_i, bus.cp0_wsel_i,
                                 CP0_REG_EPC, CP0_SEL_EPC);
   assign wr_ebase  = cp0_wr_hit(bus.cp0_we_i, bus.cp0_waddr_i, bus.cp0_wsel_i,
                                 CP0_REG_EBASE, CP0_SEL_EBASE);

   // Only the writable Status/Cause fields matter for interrupt detection
   assign im        = wr_status ? bus.cp0_wdata_i[15:8] : bus.status_i[15:8];
   assign exl       = wr_status ? bus.cp0_wdata_i[1]    : bus.status_i[1];
   assign ie        = wr_status ? bus.cp0_wdata_i[0]    : bus.status_i[0];
   assign ip_sw     = wr_cause  ? bus.cp0_wdata_i[9:8]  : bus.cause_i[9:8];
   assign epc_byp   = wr_epc    ? bus.cp0_wdata_i       : bus.epc_i;
   assign ebase_byp = wr_ebase  ? bus.cp0_wdata_i       : bus.ebase_i;

   // ---------------------------------------------------------------------
   // Interrupt detection and attachment (recomputed every cycle)
   // ---------------------------------------------------------------------
   logic int_pend, int1, int2;

   assign int_pend = ie & ~exl & (|({bus.int_i, ip_sw} & im));
   assign int1     = int_pend & bus.valid1_i;
   assign int2     = int_pend & ~bus.valid1_i & bus.valid2_i;

   // ---------------------------------------------------------------------
   // Per-slot priority and slot selection
   // ---------------------------------------------------------------------
   logic       hit1_raw, hit2_raw, hit1, hit2;
   logic [4:0] code1, code2;
   logic       exc_found;
   logic [4:0] sel_code;
   logic [31:0] sel_pc;

   exc_prio_enc u_prio_slot1 (
      .exc      (bus.exc1_i),
      .int_pend (int1),
      .hit      (hit1_raw),
      .code     (code1)
   );

   exc_prio_enc u_prio_slot2 (
      .exc      (bus.exc2_i),
      .int_pend (int2),
      .hit      (hit2_raw),
      .code     (code2)
   );

   assign hit1      = bus.valid1_i & hit1_raw;
   assign hit2      = bus.valid2_i & hit2_raw;
   assign exc_found = hit1 | hit2;
   assign sel_code  = hit1 ? code1 : code2;
   assign sel_pc    = (sel_code == EXC_ERET) ? epc_byp : ebase_byp;

   // ---------------------------------------------------------------------
   // Commit FSM
   // ---------------------------------------------------------------------
   commit_state_t    state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             commit;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      commit     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!bus.stall_i && exc_found) begin
               commit     = 1'b1;
               cnt_next   = CNT_LOAD;
               state_next = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            // Slot inputs are ignored until the flush window closes
            if (cnt == '0) state_next = ST_IDLE;
            else           cnt_next   = cnt - 1'b1;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Output registers: loaded on commit, otherwise held
   // ---------------------------------------------------------------------
   logic        flag_q, first_q, ds1_q, ds2_q;
   logic [4:0]  type_q;
   logic [31:0] inst1_q, inst2_q, mem_q, new_pc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         flag_q   <= 1'b0;
         first_q  <= 1'b0;
         type_q   <= '0;
         inst1_q  <= '0;
         inst2_q  <= '0;
         mem_q    <= '0;
         ds1_q    <= 1'b0;
         ds2_q    <= 1'b0;
         new_pc_q <= '0;
      end else begin
         flag_q <= commit;
         if (commit) begin
            first_q  <= hit1;
            type_q   <= sel_code;
            inst1_q  <= bus.inst1_addr_i;
            inst2_q  <= bus.inst2_addr_i;
            mem_q    <= bus.mem_addr_i;
            ds1_q    <= bus.ds1_i;
            ds2_q    <= bus.ds2_i;
            new_pc_q <= sel_pc;
         end
      end
   end

   assign bus.exception_flag_o       = flag_q;
   assign bus.exception_type_o       = type_q;
   assign bus.exception_first_inst_o = first_q;
   assign bus.inst1_addr_o           = inst1_q;
   assign bus.inst2_addr_o           = inst2_q;
   assign bus.mem_addr_o             = mem_q;
   assign bus.ds1_o                  = ds1_q;
   assign bus.ds2_o                  = ds2_q;
   assign bus.new_pc_o               = new_pc_q;
   assign bus.flush_o                = (state == ST_FLUSH);

endmodule
`default_nettype wire
